// File: rtl/csa_pkg.sv
// Shared types and helpers for the pipelined carry-select adder/subtractor.
package csa_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Default geometry; csa_pipe is parameterised and may be built at others.
   localparam int CSA_WIDTH = 32;
   localparam int CSA_BLOCK = 8;
   localparam int CSA_NBLK  = CSA_WIDTH / CSA_BLOCK;

   // Stage-1 state at the default geometry: both speculative sums per block,
   // the effective carry-in and the operand sign bits needed for overflow.
   typedef struct packed {
      logic [CSA_NBLK-1:0][CSA_BLOCK-1:0] sum0;
      logic [CSA_NBLK-1:0][CSA_BLOCK-1:0] sum1;
      logic [CSA_NBLK-1:0]                cout0;
      logic [CSA_NBLK-1:0]                cout1;
      logic                               cin;
      logic                               a_msb;
      logic                               b_msb;
   } s1_t;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/csa_block_dual.sv
// One carry-select block: both carry-in hypotheses computed in parallel.
module csa_block_dual #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   output logic [BLOCK-1:0] sum0,
   output logic [BLOCK-1:0] sum1,
   output logic             cout0,
   output logic             cout1
);

   assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
   assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/csa_pipe.sv
// Two-stage carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 registers per-block dual sums; stage 2 resolves the select chain.
module csa_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int BLOCK = CSA_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  op_e              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NBLK = WIDTH / BLOCK;

   if ((WIDTH % BLOCK) != 0) begin : g_bad_geometry
      $error("csa_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
   end

   // Stage-1 layout for the instantiated geometry (same fields as csa_pkg::s1_t).
   typedef struct packed {
      logic [NBLK-1:0][BLOCK-1:0] sum0;
      logic [NBLK-1:0][BLOCK-1:0] sum1;
      logic [NBLK-1:0]            cout0;
      logic [NBLK-1:0]            cout1;
      logic                       cin;
      logic                       a_msb;
      logic                       b_msb;
   } s1_local_t;

   logic                       s1_valid, s2_valid;
   logic                       adv1, adv2;
   logic [WIDTH-1:0]           b_eff;
   logic                       cin_eff;
   logic [NBLK-1:0][BLOCK-1:0] blk_sum0, blk_sum1;
   logic [NBLK-1:0]            blk_cout0, blk_cout1;
   s1_local_t                  s1_d, s1_q;
   logic [NBLK-1:0][BLOCK-1:0] sum_sel;
   logic                       chain_cout;

   // A stage moves when its successor is empty or draining this cycle.
   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   // Subtract is a + ~b + 1; the external carry-in only matters for add.
   assign b_eff   = (op == OP_SUB) ? ~b : b;
   assign cin_eff = (op == OP_SUB) ? 1'b1 : c_in;

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      csa_block_dual #(.BLOCK(BLOCK)) u_blk (
         .a     (a[k*BLOCK +: BLOCK]),
         .b     (b_eff[k*BLOCK +: BLOCK]),
         .sum0  (blk_sum0[k]),
         .sum1  (blk_sum1[k]),
         .cout0 (blk_cout0[k]),
         .cout1 (blk_cout1[k])
      );
   end

   assign s1_d = '{sum0:  blk_sum0,
                   sum1:  blk_sum1,
                   cout0: blk_cout0,
                   cout1: blk_cout1,
                   cin:   cin_eff,
                   a_msb: a[WIDTH-1],
                   b_msb: b_eff[WIDTH-1]};

   // Stage 1: capture the speculative sums on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         if (adv1) s1_valid <= in_valid;
         if (in_valid && adv1) s1_q <= s1_d;
      end
   end

   // Carry-select chain: each block's resolved carry picks the next block's sum.
   always_comb begin
      logic c;
      sum_sel = '0;
      c       = s1_q.cin;
      for (int k = 0; k < NBLK; k++) begin
         sum_sel[k] = c ? s1_q.sum1[k] : s1_q.sum0[k];
         c          = c ? s1_q.cout1[k] : s1_q.cout0[k];
      end
      chain_cout = c;
   end

   // Stage 2: register the resolved result; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s        <= '0;
         c_out    <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (adv2) s2_valid <= s1_valid;
         if (s1_valid && adv2) begin
            s     <= sum_sel;
            c_out <= chain_cout;
            ovf   <= add_ovf(s1_q.a_msb, s1_q.b_msb, sum_sel[NBLK-1][BLOCK-1]);
         end
      end
   end

endmodule

// File: tb/tb_csa_pipe.sv
// Scoreboard bench for csa_pipe at WIDTH=32, BLOCK=8.
module tb_csa_pipe;
   import csa_pkg::*;

   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, s;
   logic        c_in, c_out, ovf;
   op_e         op;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        v;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errs   = 0;
   logic        rand_bp = 1'b0;
   logic        held_v = 1'b0;
   logic [31:0] held_s = '0;

   csa_pipe #(.WIDTH(32), .BLOCK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input op_e o);
      exp_t        e;
      logic [31:0] yy;
      logic        cc;
      logic [32:0] r;
      yy  = (o == OP_SUB) ? ~y : y;
      cc  = (o == OP_SUB) ? 1'b1 : ci;
      r   = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
      e.s = r[31:0];
      e.c = r[32];
      e.v = (x[31] == yy[31]) && (r[31] != x[31]);
      return e;
   endfunction

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input op_e o);
      int n = 0;
      in_valid = 1'b1; a = x; b = y; c_in = ci; op = o;
      forever begin
         if (rand_bp) begin
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
         end
         if (in_ready || n >= 200) break;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         sb.push_back(model(x, y, ci, o));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: pop and compare on every consumed result; verify stall stability.
   always @(negedge clk) begin
      exp_t e;
      if (held_v && out_valid) chk("stall_hold_s", s, held_s);
      held_v <= out_valid && !out_ready;
      held_s <= s;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("s", s, e.s);
            chk("c_out", {31'b0, c_out}, {31'b0, e.c});
            chk("ovf", {31'b0, ovf}, {31'b0, e.v});
         end
      end
   end

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c_in = 1'b0; op = OP_ADD;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_s", s, 32'd0);
      chk("rst_c_out", {31'b0, c_out}, 32'd0);
      chk("rst_ovf", {31'b0, ovf}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Latency: result appears after the second register edge.
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD);
      chk("lat_early_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", {31'b0, out_valid}, 32'd1);
      chk("lat_s", s, 32'h0000_0100);

      // Directed corner vectors, back to back.
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD);
      send(32'd5, 32'd7, 1'b1, OP_SUB);
      send(32'd7, 32'd5, 1'b0, OP_SUB);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB);
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
      drain();

      // Backpressure: two beats fill the pipe, the third waits.
      out_ready = 1'b0;
      send(32'd1, 32'd1, 1'b0, OP_ADD);
      send(32'd2, 32'd2, 1'b0, OP_ADD);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b1; a = 32'd3; b = 32'd3; c_in = 1'b0; op = OP_ADD;
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_hold_s", s, 32'd2);
         chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
      sb.push_back(model(32'd3, 32'd3, 1'b0, OP_ADD));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_seq2_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_seq2_s", s, 32'd4);
      @(posedge clk); #1;
      chk("bp_seq3_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_seq3_s", s, 32'd6);
      @(posedge clk); #1;
      chk("bp_empty", {31'b0, out_valid}, 32'd0);

      // Random traffic with random consumer stalls.
      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++)
         send($urandom, $urandom, 1'($urandom_range(0, 1)), op_e'($urandom_range(0, 1)));
      rand_bp = 1'b0;
      drain();

      // Asynchronous reset with two beats in flight.
      out_ready = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD);
      send(32'h0000_0010, 32'h0000_0020, 1'b0, OP_ADD);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_s", s, 32'd0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(32'd9, 32'd1, 1'b0, OP_ADD);
      @(posedge clk); #1;
      chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
      chk("post_rst_s", s, 32'd10);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/csa_pipe.md
# csa_pipe

Pipelined, parametrised carry-select adder/subtractor with valid/ready handshakes on both sides. It generalises the single dual-sum block into a WIDTH-bit datapath split into WIDTH/BLOCK carry-select blocks. It adds subtract mode and a signed-overflow flag, and accepts one operation per cycle at two-cycle latency. It sits between an operand source and any consumer that can stall it.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK (elaboration `$error` otherwise)
- BLOCK, 8, bits per carry-select block; NBLK = WIDTH/BLOCK
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active low
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in (add mode only)
- op  in  1  csa_pkg::op_e: OP_ADD=0, OP_SUB=1
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result this cycle
- s  out  WIDTH  result
- c_out  out  1  carry out of MSB; in SUB it is the inverted borrow (1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Accept: a beat is accepted when in_valid && in_ready.
- Operand conditioning:
  - ADD: b' = b, carry-in = c_in.
  - SUB: b' = ~b, carry-in = 1; c_in is ignored.
- Stage 1 (registered at accept): for each block k, store
  - sum0_k/cout0_k = a_k + b'_k + 0
  - sum1_k/cout1_k = a_k + b'_k + 1
  - the effective carry-in
  - a[WIDTH-1] and b'[WIDTH-1]
- Stage 2 (registered):
  - Carry select chain: c_0 = carry-in; block k takes sum1_k if c_k else sum0_k; c_{k+1} = c_k ? cout1_k : cout0_k.
  - c_out = c_NBLK.
  - ovf = (a_msb == b'_msb) && (s[WIDTH-1] != a_msb).
- All arithmetic is unsigned modulo 2^WIDTH. No sign extension.
- Flow control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from the valids and out_ready; no combinational path from in_valid)
  - s1 → s2 transfer on s1_valid && adv2.
- Order is preserved. No beat is dropped or duplicated.

## Timing
- Latency: result is visible with out_valid=1 exactly 2 cycles after the accept edge when not stalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall behaviour:
  - While out_valid && !out_ready, s/c_out/ovf hold stable.
  - The pipeline can hold at most 2 beats. With out_ready low, in_ready falls after two beats are held.
- Simultaneous events:
  - Consume and accept in the same cycle both occur.
  - s2 is refilled from s1 on the same edge; no bubble.
- Reset:
  - rst_n low clears s1_valid, s2_valid and all data registers to 0 immediately, without waiting for clk.
  - Outputs under reset: out_valid=0, s=0, c_out=0, ovf=0, in_ready=1.
  - Reset mid-operation discards in-flight beats.
  - The first accept is possible on the first clk edge after rst_n rises.
- Wrap-around: 0xFFFF_FFFF + 1 wraps to 0 with c_out=1.

## Structure
- Package csa_pkg:
  - op_e enum
  - a stage-1 struct: per-block sum0/sum1/cout0/cout1 arrays, cin, a_msb, b_msb
- Sub-module csa_block_dual #(BLOCK): combinational; inputs a, b; outputs sum0, sum1, cout0, cout1. Instantiated NBLK times via generate.
- Select chain and handshake logic live in csa_pipe.

## Test plan (WIDTH=32, BLOCK=8)
- ADD 0x0000_00FF + 0x0000_0001, c_in=0 → s=0x0000_0100, c_out=0, ovf=0; out_valid exactly 2 cycles after accept.
- ADD 0xFFFF_FFFF + 0x0000_0000, c_in=1 → s=0, c_out=1, ovf=0 (carry crosses all 4 blocks).
- SUB 5 − 7, c_in=1 (ignored) → s=0xFFFF_FFFE, c_out=0, ovf=0. SUB 7 − 5 → s=2, c_out=1.
- ADD 0x7FFF_FFFF + 1 → s=0x8000_0000, ovf=1. SUB 0x8000_0000 − 1 → s=0x7FFF_FFFF, ovf=1.
- Backpressure: stream 3 ADD beats (1+1, 2+2, 3+3) with out_ready=0 for 4 cycles → in_ready=0 after 2 accepts; s holds at 2. After out_ready=1, results 2, 4, 6 appear in order with no gaps.
- Reset mid-stream: assert rst_n low between clock edges with 2 beats in flight → out_valid=0 and s=0 immediately. After release, a new beat 9+1 → s=10 after 2 cycles.
